axi4_resp_queue: RTL and testbench

- Parametrised FIFO for the AXI4 write-response (B) channel: buffers {resp, id, user} between slave-side response generation and master-side B output.
- Generalises the fixed single-entry B queue to:
  - configurable depth and ID/USER widths;
  - optional flow-through (FLOW) and pipelined-ready (PIPE) modes;
  - full occupancy count.
- One instance per AXI4 port in the CORERISCV_AXI4 interconnect.

---
 rtl/axi4_resp_queue.sv | 136 +++++++++++++
 tb/tb_axi4_resp_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axi4_resp_queue.sv
// Parametrised AXI4 write-response (B) channel FIFO with optional flow-through and pipelined-ready modes.
// Optional saturating error-response counter enabled by AXI4_RESP_QUEUE_ERRCNT_EN.
module axi4_resp_queue #(
  parameter int DEPTH  = 2,
  parameter int ID_W   = 5,
  parameter int USER_W = 1,
  parameter int FLOW   = 0,
  parameter int PIPE   = 0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_enq_ready,
  input  logic              io_enq_valid,
  input  logic [1:0]        io_enq_bits_resp,
  input  logic [ID_W-1:0]   io_enq_bits_id,
  input  logic [USER_W-1:0] io_enq_bits_user,
  input  logic              io_deq_ready,
  output logic              io_deq_valid,
  output logic [1:0]        io_deq_bits_resp,
  output logic [ID_W-1:0]   io_deq_bits_id,
  output logic [USER_W-1:0] io_deq_bits_user,
  output logic [CNT_W-1:0]  io_count
`ifdef AXI4_RESP_QUEUE_ERRCNT_EN
  ,output logic [7:0]       io_err_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        resp_mem_r [DEPTH];
  logic [ID_W-1:0]   id_mem_r   [DEPTH];
  logic [USER_W-1:0] user_mem_r [DEPTH];

  logic [PTR_W-1:0] enq_ptr_r;
  logic [PTR_W-1:0] deq_ptr_r;
  logic             maybe_full_r;

  logic             ptr_match_s;
  logic             empty_s;
  logic             full_s;
  logic             flow_pass_s;
  logic             do_enq_s;
  logic             do_deq_s;
  logic [CNT_W-1:0] diff_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) begin
      return {PTR_W{1'b0}};
    end else if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // Status, handshakes and head-of-queue data
  always_comb begin
    ptr_match_s  = (enq_ptr_r == deq_ptr_r);
    empty_s      = ptr_match_s & ~maybe_full_r;
    full_s       = ptr_match_s & maybe_full_r;
    io_enq_ready = ~full_s | ((PIPE != 0) & io_deq_ready);
    io_deq_valid = ~empty_s | ((FLOW != 0) & io_enq_valid);
    // An entry passing straight through an empty FLOW queue never touches storage.
    flow_pass_s  = (FLOW != 0) & empty_s & io_deq_ready;
    do_enq_s     = io_enq_ready & io_enq_valid & ~flow_pass_s;
    do_deq_s     = io_deq_ready & io_deq_valid & ~flow_pass_s;
    if ((FLOW != 0) && empty_s) begin
      io_deq_bits_resp = io_enq_bits_resp;
      io_deq_bits_id   = io_enq_bits_id;
      io_deq_bits_user = io_enq_bits_user;
    end else begin
      io_deq_bits_resp = resp_mem_r[deq_ptr_r];
      io_deq_bits_id   = id_mem_r[deq_ptr_r];
      io_deq_bits_user = user_mem_r[deq_ptr_r];
    end
  end

  // Occupancy from pointer distance, modulo a possibly non-power-of-two depth
  always_comb begin
    diff_s = CNT_W'(enq_ptr_r) - CNT_W'(deq_ptr_r);
    if (ptr_match_s) begin
      io_count = maybe_full_r ? CNT_W'(DEPTH) : {CNT_W{1'b0}};
    end else if (enq_ptr_r > deq_ptr_r) begin
      io_count = diff_s;
    end else begin
      io_count = diff_s + CNT_W'(DEPTH);
    end
  end

  // Pointer and full-flag state
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_r    <= {PTR_W{1'b0}};
      deq_ptr_r    <= {PTR_W{1'b0}};
      maybe_full_r <= 1'b0;
    end else begin
      if (do_enq_s) begin
        enq_ptr_r <= ptr_inc(enq_ptr_r);
      end
      if (do_deq_s) begin
        deq_ptr_r <= ptr_inc(deq_ptr_r);
      end
      if (do_enq_s != do_deq_s) begin
        maybe_full_r <= do_enq_s;
      end
    end
  end

  // Entry storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_enq_s) begin
      resp_mem_r[enq_ptr_r] <= io_enq_bits_resp;
      id_mem_r[enq_ptr_r]   <= io_enq_bits_id;
      user_mem_r[enq_ptr_r] <= io_enq_bits_user;
    end
  end

`ifdef AXI4_RESP_QUEUE_ERRCNT_EN
  logic [7:0] err_cnt_r;
  logic       err_evt_s;

  assign err_evt_s    = (do_deq_s | (flow_pass_s & io_enq_valid)) & io_deq_bits_resp[1];
  assign io_err_count = err_cnt_r;

  // Saturating count of SLVERR/DECERR responses delivered
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_r <= 8'd0;
    end else if (err_evt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_resp_queue.sv
// Scoreboard bench for axi4_resp_queue: four configurations share one random/directed stimulus stream,
// each checked every cycle against a queue-based reference model.
module tb_axi4_resp_queue;

  typedef struct packed {
    logic [1:0] resp;
    logic [4:0] id;
    logic [0:0] user;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_valid;
  logic [1:0] enq_resp;
  logic [4:0] enq_id;
  logic [0:0] enq_user;
  logic       deq_ready;

  int chk_total  = 0;
  int fail_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 3 : 2);
    localparam int F = (g == 2) ? 1 : 0;
    localparam int P = (g == 3) ? 1 : 0;
    localparam int CW = $clog2(D + 1);

    logic          enq_ready;
    logic          deq_valid;
    logic [1:0]    deq_resp;
    logic [4:0]    deq_id;
    logic [0:0]    deq_user;
    logic [CW-1:0] count;
`ifdef AXI4_RESP_QUEUE_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    ent_t q[$];
    int err_m = 0;

    axi4_resp_queue #(.DEPTH(D), .ID_W(5), .USER_W(1), .FLOW(F), .PIPE(P)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .io_enq_ready     (enq_ready),
      .io_enq_valid     (enq_valid),
      .io_enq_bits_resp (enq_resp),
      .io_enq_bits_id   (enq_id),
      .io_enq_bits_user (enq_user),
      .io_deq_ready     (deq_ready),
      .io_deq_valid     (deq_valid),
      .io_deq_bits_resp (deq_resp),
      .io_deq_bits_id   (deq_id),
      .io_deq_bits_user (deq_user),
      .io_count         (count)
`ifdef AXI4_RESP_QUEUE_ERRCNT_EN
      ,.io_err_count    (err_count)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_total++;
      if (act !== exp) begin
        fail_total++;
        $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
      end
    endtask

    // Monitor: compare outputs with the model mid-cycle, then advance the model for the coming edge
    always @(negedge clk) begin
      int   sz;
      bit   exp_er, exp_dv, flow;
      ent_t head;
      ent_t popped;
      sz     = q.size();
      exp_er = (sz < D) || ((P != 0) && deq_ready);
      exp_dv = (sz > 0) || ((F != 0) && enq_valid);
      check("enq_ready", 32'(enq_ready), 32'(exp_er));
      check("deq_valid", 32'(deq_valid), 32'(exp_dv));
      check("count", 32'(count), 32'(sz));
      if (exp_dv) begin
        head = (sz > 0) ? q[0] : '{resp: enq_resp, id: enq_id, user: enq_user};
        check("deq_resp", 32'(deq_resp), 32'(head.resp));
        check("deq_id", 32'(deq_id), 32'(head.id));
        check("deq_user", 32'(deq_user), 32'(head.user));
      end
`ifdef AXI4_RESP_QUEUE_ERRCNT_EN
      check("err_count", 32'(err_count), 32'(err_m));
`endif
      if (reset) begin
        q.delete();
        err_m = 0;
      end else begin
        flow = (F != 0) && (sz == 0) && enq_valid && deq_ready;
        if (flow) begin
          if (enq_resp[1] && err_m < 255) err_m++;
        end else begin
          if (deq_ready && sz > 0) begin
            popped = q.pop_front();
            if (popped.resp[1] && err_m < 255) err_m++;
          end
          if (enq_valid && exp_er) q.push_back('{resp: enq_resp, id: enq_id, user: enq_user});
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic ev, input logic [1:0] rsp,
                     input logic [4:0] id, input logic dr);
    reset     = rst;
    enq_valid = ev;
    enq_resp  = rsp;
    enq_id    = id;
    enq_user  = id[0];
    deq_ready = dr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
    // fill ids 1..4, hold, then drain in order
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 2'(i), 5'(i), 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 5'd5, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
    // steady-state wrap at occupancy 2
    cyc(1'b0, 1'b1, 2'b00, 5'd10, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 5'd11, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 2'(i), 5'(12 + i), 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
    // flow-through on an empty queue
    cyc(1'b0, 1'b1, 2'b10, 5'd7, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
    // fill to full, then simultaneous enq/deq
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'b01, 5'(20 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b11, 5'(24 + i), 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
    // reset with entries queued and enqueue pending
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b00, 5'(28 + i), 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 5'd31, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
    // random traffic with occasional reset
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    cyc(1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
    // error-response saturation, then non-error responses
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 2'b11, 5'(i), 1'b1);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 2'($urandom_range(0, 1)), 5'(i), 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", chk_total, fail_total);
    $finish;
  end

endmodule
